// File: rtl/nnlut_requant_pack.sv
`default_nettype none
// ============================================================================
// Module      : nnlut_requant_pack
// Description : Requantizes the signed k*x+b stream from the NN-LUT stage to
//               int8 (programmable rounding right-shift plus saturation). It
//               packs LANES bytes per word and buffers the words in a small
//               fall-through FIFO, which feeds the writeback path over an
//               active-low valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nnlut_requant_pack #(
   parameter int DIN_WIDTH   = 41,
   parameter int SHIFT_WIDTH = 6,
   parameter int LANES       = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk_p,
   input  logic                   rst_p,
   input  logic [DIN_WIDTH-1:0]   din,
   input  logic                   din_valid_n,
   input  logic                   din_last_n,
   input  logic [SHIFT_WIDTH-1:0] cfg_shift,
   output logic [8*LANES-1:0]     dout,
   output logic [LANES-1:0]       dout_keep,
   output logic                   dout_last,
   output logic                   dout_valid_n,
   input  logic                   dout_ready_n,
   output logic [CNT_WIDTH-1:0]   sat_cnt,
   output logic                   ovf_err
);

   // One extra bit of headroom so din plus the rounding constant cannot wrap
   localparam int EXT_W  = DIN_WIDTH + 1;
   localparam int MAX_SH = DIN_WIDTH - 1;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNTF_W = $clog2(FIFO_DEPTH + 1);
   localparam int WORD_W = 8*LANES + LANES + 1;

   // ---------------------------------------------------------------------
   // Stage S1: round-half-up arithmetic right shift
   // ---------------------------------------------------------------------
   logic [SHIFT_WIDTH-1:0]   w_sh;
   logic signed [EXT_W-1:0]  w_ext;
   logic signed [EXT_W-1:0]  w_half;
   logic signed [EXT_W-1:0]  w_sum;
   logic signed [EXT_W-1:0]  w_rnd;

   logic                     s1_vld_q;
   logic                     s1_last_q;
   logic signed [EXT_W-1:0]  s1_val_q;

   // Clamp the shift so a shift never exceeds the magnitude bits of din
   always_comb begin
      w_sh = cfg_shift;
      if (int'(cfg_shift) > MAX_SH) begin
         w_sh = SHIFT_WIDTH'(MAX_SH);
      end
   end

   // Add half an LSB of the result, then shift arithmetically (ties go to +inf)
   always_comb begin
      w_ext  = {din[DIN_WIDTH-1], din};
      w_half = '0;
      if (w_sh != '0) begin
         w_half = EXT_W'(1) << (w_sh - SHIFT_WIDTH'(1));
      end
      w_sum = w_ext + w_half;
      w_rnd = (w_sh == '0) ? w_ext : (w_sum >>> w_sh);
   end

   // Capture the rounded value with its valid and last flags
   always_ff @(posedge clk_p) begin
      if (rst_p) begin
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_val_q  <= '0;
      end else begin
         s1_vld_q  <= ~din_valid_n;
         s1_last_q <= ~din_valid_n & ~din_last_n;
         if (!din_valid_n) begin
            s1_val_q <= w_rnd;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage S2: saturate to int8 and pack into lanes
   // ---------------------------------------------------------------------
   logic                     w_fits;
   logic [7:0]               w_byte;
   logic [8*LANES-1:0]       w_word_data;
   logic [LANES-1:0]         w_word_keep;
   logic                     w_push;

   logic [8*LANES-1:0]       pack_q, pack_d;
   logic [LANES-1:0]         keep_q, keep_d;
   logic [LANE_W-1:0]        lane_q, lane_d;
   logic [CNT_WIDTH-1:0]     sat_q;

   // A value fits int8 when bits [MSB:7] are all copies of the sign
   always_comb begin
      w_fits = (&s1_val_q[EXT_W-1:7]) | ~(|s1_val_q[EXT_W-1:7]);
      w_byte = w_fits ? s1_val_q[7:0] : (s1_val_q[EXT_W-1] ? 8'h80 : 8'h7F);
   end

   // Merge the new byte into the pack register and decide whether the word closes
   always_comb begin
      w_word_data = pack_q;
      w_word_keep = keep_q;
      for (int i = 0; i < LANES; i++) begin
         if (lane_q == LANE_W'(i)) begin
            w_word_data[8*i +: 8] = w_byte;
            w_word_keep[i]        = 1'b1;
         end
      end
      pack_d = pack_q;
      keep_d = keep_q;
      lane_d = lane_q;
      w_push = 1'b0;
      if (s1_vld_q) begin
         if ((lane_q == LANE_W'(LANES-1)) || s1_last_q) begin
            w_push = 1'b1;
            pack_d = '0;
            keep_d = '0;
            lane_d = '0;
         end else begin
            pack_d = w_word_data;
            keep_d = w_word_keep;
            lane_d = lane_q + LANE_W'(1);
         end
      end
   end

   // Pack state and the saturating clip counter
   always_ff @(posedge clk_p) begin
      if (rst_p) begin
         pack_q <= '0;
         keep_q <= '0;
         lane_q <= '0;
         sat_q  <= '0;
      end else begin
         pack_q <= pack_d;
         keep_q <= keep_d;
         lane_q <= lane_d;
         if (s1_vld_q && !w_fits && (sat_q != '1)) begin
            sat_q <= sat_q + CNT_WIDTH'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output FIFO: first-word fall-through, head read straight from storage
   // ---------------------------------------------------------------------
   logic [WORD_W-1:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q;
   logic [PTR_W-1:0]         rd_ptr_q;
   logic [CNTF_W-1:0]        cnt_q;
   logic                     ovf_q;
   logic                     w_empty;
   logic                     w_full;
   logic                     w_pop;
   logic                     w_wr;
   logic [WORD_W-1:0]        w_head;

   // A pop in the same edge frees the slot, so a push into a full FIFO is still taken
   always_comb begin
      w_empty = (cnt_q == '0);
      w_full  = (cnt_q == CNTF_W'(FIFO_DEPTH));
      w_pop   = ~w_empty & ~dout_ready_n;
      w_wr    = w_push & (~w_full | w_pop);
      w_head  = mem_q[rd_ptr_q];
   end

   // Word storage needs no reset: the head is masked whenever the FIFO is empty
   always_ff @(posedge clk_p) begin
      if (w_wr) begin
         mem_q[wr_ptr_q] <= {s1_last_q, w_word_keep, w_word_data};
      end
   end

   // Pointers, occupancy and the sticky drop flag
   always_ff @(posedge clk_p) begin
      if (rst_p) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (w_wr) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (w_wr && !w_pop) begin
            cnt_q <= cnt_q + CNTF_W'(1);
         end else if (!w_wr && w_pop) begin
            cnt_q <= cnt_q - CNTF_W'(1);
         end
         if (w_push && !w_wr) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign dout         = w_empty ? '0 : w_head[8*LANES-1:0];
   assign dout_keep    = w_empty ? '0 : w_head[8*LANES +: LANES];
   assign dout_last    = w_empty ? 1'b0 : w_head[WORD_W-1];
   assign dout_valid_n = w_empty;
   assign sat_cnt      = sat_q;
   assign ovf_err      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nnlut_requant_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_nnlut_requant_pack
// Description : Self-checking bench for nnlut_requant_pack. A reference model
//               queues expected words as elements are driven; each output
//               handshake pops and compares one entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nnlut_requant_pack;

   logic        clk_p;
   logic        rst_p;
   logic [40:0] din;
   logic        din_valid_n;
   logic        din_last_n;
   logic [5:0]  cfg_shift;
   logic [31:0] dout;
   logic [3:0]  dout_keep;
   logic        dout_last;
   logic        dout_valid_n;
   logic        dout_ready_n;
   logic [15:0] sat_cnt;
   logic        ovf_err;

   int          checks = 0;
   int          errors = 0;
   logic [36:0] exp_q[$];
   logic [31:0] m_pack;
   logic [3:0]  m_keep;
   int          m_lane;
   int          m_sat;

   nnlut_requant_pack #(
      .DIN_WIDTH   (41),
      .SHIFT_WIDTH (6),
      .LANES       (4),
      .FIFO_DEPTH  (4),
      .CNT_WIDTH   (16)
   ) dut (
      .clk_p        (clk_p),
      .rst_p        (rst_p),
      .din          (din),
      .din_valid_n  (din_valid_n),
      .din_last_n   (din_last_n),
      .cfg_shift    (cfg_shift),
      .dout         (dout),
      .dout_keep    (dout_keep),
      .dout_last    (dout_last),
      .dout_valid_n (dout_valid_n),
      .dout_ready_n (dout_ready_n),
      .sat_cnt      (sat_cnt),
      .ovf_err      (ovf_err)
   );

   initial clk_p = 1'b0;
   always #5 clk_p = ~clk_p;

   // Watchdog so the run always ends on its own
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "watchdog expired");
   end

   // Reference requantizer: clamp shift, round half up, clip to int8
   function automatic logic [7:0] requant(input longint d, input int sh, output bit sat);
      longint r;
      int     s;
      s = (sh > 40) ? 40 : sh;
      if (s == 0) r = d;
      else        r = (d + (longint'(1) <<< (s - 1))) >>> s;
      sat = 1'b0;
      if (r > 127) begin
         sat = 1'b1;
         return 8'h7F;
      end
      if (r < -128) begin
         sat = 1'b1;
         return 8'h80;
      end
      return r[7:0];
   endfunction

   task automatic model_clear();
      m_pack = '0;
      m_keep = '0;
      m_lane = 0;
      m_sat  = 0;
      exp_q.delete();
   endtask

   // One clock: scoreboard pop on a handshake, return 1 time unit after the edge
   task automatic step();
      logic [36:0] e;
      @(negedge clk_p);
      if (!dout_valid_n && !dout_ready_n) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got last=%b keep=%b dout=%h, required no word", dout_last, dout_keep, dout);
         end else begin
            e = exp_q.pop_front();
            if ({dout_last, dout_keep, dout} !== e) begin
               errors++;
               $display("FAIL sb_word: got last=%b keep=%b dout=%h, required last=%b keep=%b dout=%h",
                        dout_last, dout_keep, dout, e[36], e[35:32], e[31:0]);
            end
         end
      end
      @(posedge clk_p);
      #1;
   endtask

   // Drive one element for one cycle and update the reference model
   task automatic send(input longint d, input bit last);
      logic [7:0] b;
      bit         s;
      din         = d[40:0];
      din_valid_n = 1'b0;
      din_last_n  = ~last;
      b = requant(d, int'(cfg_shift), s);
      if (s) m_sat++;
      m_pack[8*m_lane +: 8] = b;
      m_keep[m_lane]        = 1'b1;
      if ((m_lane == 3) || last) begin
         exp_q.push_back({last, m_keep, m_pack});
         m_pack = '0;
         m_keep = '0;
         m_lane = 0;
      end else begin
         m_lane++;
      end
      step();
   endtask

   task automatic do_reset();
      rst_p        = 1'b1;
      din_valid_n  = 1'b1;
      din_last_n   = 1'b1;
      dout_ready_n = 1'b1;
      model_clear();
      step();
      step();
      rst_p = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h, required 0", dout); end
      checks++; if (dout_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %b, required 0000", dout_keep); end
      checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, required 0", dout_last); end
      checks++; if (dout_valid_n !== 1'b1) begin errors++; $display("FAIL reset_valid_n: got %b, required 1", dout_valid_n); end
      checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL reset_sat: got %0d, required 0", sat_cnt); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", ovf_err); end
   endtask

   task automatic test_basic();
      cfg_shift    = 6'd4;
      dout_ready_n = 1'b1;
      send(24, 0);
      send(-24, 0);
      send(40, 0);
      send(-8, 1);
      din_valid_n = 1'b1;
      checks++; if (dout_valid_n !== 1'b1) begin errors++; $display("FAIL basic_early: valid_n got %b at T+1, required 1", dout_valid_n); end
      step();
      checks++; if (dout_valid_n !== 1'b0) begin errors++; $display("FAIL basic_latency: valid_n got %b at T+2, required 0", dout_valid_n); end
      checks++; if (dout !== 32'h0003FF02) begin errors++; $display("FAIL basic_word: got %h, required 0003ff02", dout); end
      checks++; if (dout_keep !== 4'hF) begin errors++; $display("FAIL basic_keep: got %b, required 1111", dout_keep); end
      checks++; if (dout_last !== 1'b1) begin errors++; $display("FAIL basic_last: got %b, required 1", dout_last); end
      step();
      checks++; if (dout_keep !== 4'hF) begin errors++; $display("FAIL basic_hold: keep got %b while stalled, required 1111", dout_keep); end
      dout_ready_n = 1'b0;
      step();
      dout_ready_n = 1'b1;
      checks++; if (dout_valid_n !== 1'b1) begin errors++; $display("FAIL basic_drain: valid_n got %b, required 1", dout_valid_n); end
   endtask

   task automatic test_saturation();
      cfg_shift    = 6'd0;
      dout_ready_n = 1'b1;
      send(5000, 0);
      send(-5000, 0);
      send(127, 0);
      send(-128, 0);
      din_valid_n = 1'b1;
      step();
      checks++; if (dout !== 32'h807F807F) begin errors++; $display("FAIL sat_word: got %h, required 807f807f", dout); end
      checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL sat_last: got %b, required 0", dout_last); end
      checks++; if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt: got %0d, required 2", sat_cnt); end
      dout_ready_n = 1'b0;
      step();
      dout_ready_n = 1'b1;
   endtask

   task automatic test_short_vector();
      cfg_shift    = 6'd2;
      dout_ready_n = 1'b1;
      send(4, 0);
      send(8, 0);
      send(12, 1);
      din_valid_n = 1'b1;
      step();
      checks++; if (dout !== 32'h00030201) begin errors++; $display("FAIL short_word: got %h, required 00030201", dout); end
      checks++; if (dout_keep !== 4'b0111) begin errors++; $display("FAIL short_keep: got %b, required 0111", dout_keep); end
      checks++; if (dout_last !== 1'b1) begin errors++; $display("FAIL short_last: got %b, required 1", dout_last); end
      dout_ready_n = 1'b0;
      step();
      dout_ready_n = 1'b1;
      send(4, 0);
      send(4, 0);
      din_valid_n = 1'b1;
      step();
      send(4, 0);
      send(4, 0);
      din_valid_n = 1'b1;
      step();
      checks++; if (dout !== 32'h01010101) begin errors++; $display("FAIL short_next: got %h, required 01010101", dout); end
      checks++; if (dout_keep !== 4'hF) begin errors++; $display("FAIL short_next_keep: got %b, required 1111", dout_keep); end
      dout_ready_n = 1'b0;
      step();
      dout_ready_n = 1'b1;
   endtask

   task automatic test_overflow();
      longint d;
      cfg_shift    = 6'd3;
      dout_ready_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 7)       d = -(longint'(1) <<< 40);
         else if (i == 13) d = (longint'(1) <<< 40) - 1;
         else              d = longint'($urandom_range(0, 4000)) - 2000;
         send(d, 0);
      end
      din_valid_n = 1'b1;
      void'(exp_q.pop_back());
      step();
      step();
      step();
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", ovf_err); end
      checks++; if (sat_cnt !== 16'(m_sat)) begin errors++; $display("FAIL ovf_sat: got %0d, required %0d", sat_cnt, m_sat); end
      dout_ready_n = 1'b0;
      for (int k = 0; k < 4; k++) step();
      dout_ready_n = 1'b1;
      checks++; if (dout_valid_n !== 1'b1) begin errors++; $display("FAIL ovf_drain: valid_n got %b after 4 pops, required 1", dout_valid_n); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_count: %0d words not seen, required 0", exp_q.size()); end
   endtask

   task automatic test_full_same_edge();
      int n;
      do_reset();
      cfg_shift    = 6'd1;
      dout_ready_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(longint'($urandom_range(0, 600)) - 300, 0);
      end
      din_valid_n  = 1'b1;
      dout_ready_n = 1'b0;
      step();
      dout_ready_n = 1'b1;
      step();
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL full_pop_ovf: got %b, required 0", ovf_err); end
      n = 0;
      dout_ready_n = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (dout_valid_n) break;
         step();
         n++;
      end
      dout_ready_n = 1'b1;
      checks++; if (n != 4) begin errors++; $display("FAIL full_pop_count: drained %0d words, required 4", n); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_pop_left: %0d words not seen, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      cfg_shift    = 6'd0;
      dout_ready_n = 1'b1;
      for (int i = 1; i <= 10; i++) send(i, 0);
      rst_p       = 1'b1;
      din_valid_n = 1'b1;
      model_clear();
      step();
      rst_p = 1'b0;
      checks++; if (dout_valid_n !== 1'b1) begin errors++; $display("FAIL mid_valid_n: got %b, required 1", dout_valid_n); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL mid_dout: got %h, required 0", dout); end
      checks++; if (dout_keep !== 4'h0) begin errors++; $display("FAIL mid_keep: got %b, required 0000", dout_keep); end
      checks++; if (ovf_err !== 1'b0 || sat_cnt !== 16'd0) begin errors++; $display("FAIL mid_status: ovf=%b sat=%0d, required 0 and 0", ovf_err, sat_cnt); end
      for (int i = 1; i <= 4; i++) send(i, 0);
      din_valid_n = 1'b1;
      step();
      checks++; if (dout !== 32'h04030201) begin errors++; $display("FAIL mid_word: got %h, required 04030201", dout); end
      checks++; if (dout_keep !== 4'hF) begin errors++; $display("FAIL mid_word_keep: got %b, required 1111", dout_keep); end
      dout_ready_n = 1'b0;
      step();
      dout_ready_n = 1'b1;
      step();
      checks++; if (dout_valid_n !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL mid_end: valid_n=%b left=%0d, required 1 and 0", dout_valid_n, exp_q.size()); end
   endtask

   initial begin
      rst_p        = 1'b1;
      din          = '0;
      din_valid_n  = 1'b1;
      din_last_n   = 1'b1;
      cfg_shift    = '0;
      dout_ready_n = 1'b1;
      model_clear();
      test_reset();
      test_basic();
      test_saturation();
      test_short_vector();
      test_overflow();
      test_full_same_edge();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nnlut_requant_pack.md
Name: nnlut_requant_pack

Overview:
- Downstream consumer of the NN-LUT activation stage (GELU etc.).
- Takes the 41-bit signed k*x+b result stream (active-low valid, no backpressure), requantizes each element to int8 with a programmable right-shift, round-half-up and saturation.
- Packs 4 int8 lanes per 32-bit word and buffers the words in a small FIFO.
- Presents the words to the writeback path over an active-low valid/ready handshake.

Parameters:
- DIN_WIDTH, 41, width of signed input element (8-bit x * 32-bit k + 32-bit b).
- SHIFT_WIDTH, 6, width of cfg_shift.
- LANES, 4, int8 lanes per output word.
- FIFO_DEPTH, 4, output FIFO depth in words; power of two.
- CNT_WIDTH, 16, width of saturation counter.

Ports:
- clk_p  in  1  clock, all logic on rising edge.
- rst_p  in  1  synchronous, active-high reset.
- din  in  DIN_WIDTH  signed activation result.
- din_valid_n  in  1  active-low; din sampled when 0.
- din_last_n  in  1  active-low; marks last element of a vector, qualified by din_valid_n.
- cfg_shift  in  SHIFT_WIDTH  right-shift amount; static while data is in flight.
- dout  out  8*LANES  packed word; lane i in bits [8i+7:8i], lane 0 = earliest element.
- dout_keep  out  LANES  lane-valid mask of dout.
- dout_last  out  1  word closes a vector.
- dout_valid_n  out  1  active-low; FIFO head valid.
- dout_ready_n  in  1  active-low consumer ready.
- sat_cnt  out  CNT_WIDTH  count of saturated elements; saturates at all-ones.
- ovf_err  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (rst_p=1 at an edge): pipeline valids cleared, pack register, lane index, keep mask cleared, FIFO emptied.
  - dout=0, dout_keep=0, dout_last=0, dout_valid_n=1, sat_cnt=0, ovf_err=0.
  - Reset mid-vector discards any partial word and all buffered words.
- Transfer rules:
  - Input accepted on every edge with din_valid_n=0; there is no stall toward upstream.
  - Output transfer occurs on an edge with dout_valid_n=0 and dout_ready_n=0.
- Stage S1 (edge after accept): s1_val = round-shift of din using a 42-bit intermediate.
  - sh = min(cfg_shift, 40).
  - sh=0 gives din unchanged.
  - Otherwise (din + 2^(sh-1)) >>> sh, i.e. round half toward +inf.
  - S1 also registers its valid and last bits.
- Stage S2 (next edge), only when S1 is valid:
  - byte = s1_val clipped to [-128,127].
  - sat_cnt increments if clipped, holds at max.
  - Byte is written to pack lane lane_idx and the keep bit is set.
  - If lane_idx==LANES-1 or S1 last: the word {pack with new byte, keep, last} is pushed to the FIFO; pack, keep and lane_idx clear.
  - Otherwise lane_idx increments.
  - Unused lanes of a short (last) word are 0 with keep=0.
- Latency: the element that completes a word is accepted in cycle T; dout_valid_n=0 in cycle T+2 if the FIFO was empty.
- FIFO: registered head, first-word fall-through, count 0..FIFO_DEPTH.
  - Push when full with no pop that edge: word dropped, ovf_err set to 1, held until reset. Pack state still clears.
  - Push when full with a pop the same edge: allowed, count unchanged.
  - Push and pop when empty: the pushed word appears at the head next cycle; the pop is a no-op since dout_valid_n=1.
  - Pointers wrap modulo FIFO_DEPTH.
- dout/dout_keep/dout_last hold stable while dout_valid_n=0 and dout_ready_n=1.
- Bubbles (din_valid_n=1) do not advance lane_idx. din_last_n is ignored when din_valid_n=1.
- dout is 0 when the FIFO is empty.

Test Plan:
- cfg_shift=4; din=24,-24,40,-8 back-to-back, last on 4th -> lanes 2,-1,3,0 (word 0x0003FF02), keep=4'b1111, dout_last=1, dout_valid_n low 2 cycles after 4th input.
- cfg_shift=0; din=5000,-5000,127,-128 -> word 0x807F807F; sat_cnt=2.
- cfg_shift=2; 3 elements din=4,8,12 with last on 3rd -> dout=0x00030201, keep=4'b0111, last=1; next vector starts at lane 0.
- dout_ready_n=1 held; 20 consecutive elements (5 words) -> 4 words buffered, 5th dropped, ovf_err=1. Release ready -> exactly 4 words drain in order, dout_valid_n=1 after the 4th pop.
- FIFO full, dout_ready_n=0 on the same edge a 5th word is pushed -> no drop, ovf_err stays 0, count stays 4.
- rst_p pulsed after 2 elements of a vector and with 2 words buffered -> all outputs at reset values next cycle; the following 4 elements form a clean word starting at lane 0.
